// File: rtl/sat_add_pipe.sv
// Two-stage pipelined adder: wrap, full-width saturating, lane-wise saturating and saturating subtract.
// Lower half is added in stage 1; stage 2 finishes the upper half and applies clamping.
module sat_add_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             clr_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             ovf_sticky
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned NLANE = HALF / LANE;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SAT  = 2'b01;
  localparam logic [1:0] OP_LANE = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Lane-wise saturating add over one half; returns {any_clamp, result}.
  function automatic logic [HALF:0] lane_sat(input logic [HALF-1:0] x, input logic [HALF-1:0] y);
    logic [HALF-1:0] r;
    logic            o;
    logic [LANE-1:0] xs;
    logic [LANE-1:0] ys;
    logic [LANE-1:0] s;
    r = '0;
    o = 1'b0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      xs = x[i*LANE +: LANE];
      ys = y[i*LANE +: LANE];
      s  = xs + ys;
      if ((xs[LANE-1] == ys[LANE-1]) && (s[LANE-1] != xs[LANE-1])) begin
        o = 1'b1;
        s = xs[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
      end
      r[i*LANE +: LANE] = s;
    end
    return {o, r};
  endfunction

  logic            s1_valid_q,  s1_valid_d;
  logic [HALF-1:0] s1_lo_q,     s1_lo_d;
  logic            s1_cy_q,     s1_cy_d;
  logic            s1_lo_ovf_q, s1_lo_ovf_d;
  logic [HALF-1:0] s1_a_hi_q,   s1_a_hi_d;
  logic [HALF-1:0] s1_b_hi_q,   s1_b_hi_d;
  logic [1:0]      s1_op_q,     s1_op_d;

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] sum_q,        sum_d;
  logic             co_q,         co_d;
  logic             ovf_q,        ovf_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic             advance_c;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [HALF:0]    lo_add;
  logic [HALF:0]    lo_lane;
  logic [HALF:0]    hi_add;
  logic [HALF:0]    hi_lane;
  logic             full_ovf;
  logic [WIDTH-1:0] full_sum;
  logic [WIDTH-1:0] sat_val;

  assign advance_c = ~out_valid_q | out_ready;
  assign in_ready  = advance_c;

  // Stage 1: lower-half add (subtract folds in as ~b + 1), carry toward the upper half.
  always_comb begin
    b_eff       = (op == OP_SUB) ? ~b : b;
    cin         = (op == OP_SUB);
    lo_add      = {1'b0, a[HALF-1:0]} + {1'b0, b_eff[HALF-1:0]} + (HALF+1)'(cin);
    lo_lane     = lane_sat(a[HALF-1:0], b[HALF-1:0]);
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_cy_d     = s1_cy_q;
    s1_lo_ovf_d = s1_lo_ovf_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    s1_op_d     = s1_op_q;
    if (advance_c) begin
      s1_valid_d  = in_valid;
      s1_lo_d     = (op == OP_LANE) ? lo_lane[HALF-1:0] : lo_add[HALF-1:0];
      s1_cy_d     = (op == OP_LANE) ? 1'b0 : lo_add[HALF];
      s1_lo_ovf_d = (op == OP_LANE) & lo_lane[HALF];
      s1_a_hi_d   = a[WIDTH-1:HALF];
      s1_b_hi_d   = b_eff[WIDTH-1:HALF];
      s1_op_d     = op;
    end
  end

  // Stage 2: upper half, saturation select and sticky flag.
  always_comb begin
    hi_add   = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q} + (HALF+1)'(s1_cy_q);
    hi_lane  = lane_sat(s1_a_hi_q, s1_b_hi_q);
    full_ovf = (s1_a_hi_q[HALF-1] == s1_b_hi_q[HALF-1]) && (hi_add[HALF-1] != s1_a_hi_q[HALF-1]);
    full_sum = {hi_add[HALF-1:0], s1_lo_q};
    sat_val  = s1_a_hi_q[HALF-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    out_valid_d  = out_valid_q;
    sum_d        = sum_q;
    co_d         = co_q;
    ovf_d        = ovf_q;
    ovf_sticky_d = ovf_sticky_q;

    if (advance_c) begin
      out_valid_d = s1_valid_q;
      case (s1_op_q)
        OP_ADD: begin
          sum_d = full_sum;
          co_d  = hi_add[HALF];
          ovf_d = full_ovf;
        end
        OP_LANE: begin
          sum_d = {hi_lane[HALF-1:0], s1_lo_q};
          co_d  = 1'b0;
          ovf_d = hi_lane[HALF] | s1_lo_ovf_q;
        end
        OP_SAT, OP_SUB: begin
          sum_d = full_ovf ? sat_val : full_sum;
          co_d  = hi_add[HALF];
          ovf_d = full_ovf;
        end
        default: begin
          sum_d = full_sum;
          co_d  = hi_add[HALF];
          ovf_d = full_ovf;
        end
      endcase
    end

    // A flagged handover wins over a same-cycle clear.
    if (out_valid_q && out_ready && ovf_q) begin
      ovf_sticky_d = 1'b1;
    end else if (clr_flags) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_lo_q      <= '0;
      s1_cy_q      <= 1'b0;
      s1_lo_ovf_q  <= 1'b0;
      s1_a_hi_q    <= '0;
      s1_b_hi_q    <= '0;
      s1_op_q      <= 2'b00;
      out_valid_q  <= 1'b0;
      sum_q        <= '0;
      co_q         <= 1'b0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_lo_q      <= s1_lo_d;
      s1_cy_q      <= s1_cy_d;
      s1_lo_ovf_q  <= s1_lo_ovf_d;
      s1_a_hi_q    <= s1_a_hi_d;
      s1_b_hi_q    <= s1_b_hi_d;
      s1_op_q      <= s1_op_d;
      out_valid_q  <= out_valid_d;
      sum_q        <= sum_d;
      co_q         <= co_d;
      ovf_q        <= ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign sum        = sum_q;
  assign co         = co_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_sat_add_pipe.sv
// Scoreboard bench for sat_add_pipe: directed vectors queued on acceptance, checked on handover.
module tb_sat_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic [1:0]  op = 2'b00;
  logic        clr_flags = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        co;
  logic        ovf;
  logic        ovf_sticky;

  sat_add_pipe #(.WIDTH(16), .LANE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .clr_flags(clr_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic exp_sticky = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake rule, sticky flag, and in-order result comparison.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("co", 32'(co), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.o));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          if (e.o) exp_sticky = 1'b1;
          else if (clr_flags) exp_sticky = 1'b0;
        end
      end else if (clr_flags) begin
        exp_sticky = 1'b0;
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] top,
                      input logic [15:0] es, input logic ec, input logic eo, input bit chk_lat);
    int  n = 0;
    bit  done = 0;
    exp_t e;
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = es; e.c = ec; e.o = eo; e.acc = cyc; e.lat = chk_lat;
        sb.push_back(e);
        done = 1;
      end else if (++n > 50) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, consumer always ready: latency must be exactly 2.
    send(16'h7000, 16'h1000, 2'b01, 16'h7FFF, 1'b0, 1'b1, 1);
    send(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 1);
    send(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b1, 1);
    send(16'h783F, 16'h1F21, 2'b10, 16'h7850, 1'b0, 1'b1, 1);
    send(16'h1234, 16'h1111, 2'b10, 16'h2345, 1'b0, 1'b0, 1);
    send(16'h8000, 16'h0001, 2'b11, 16'h8000, 1'b1, 1'b1, 1);
    send(16'h0005, 16'h0003, 2'b11, 16'h0002, 1'b1, 1'b0, 1);
    send(16'h8000, 16'hFFFF, 2'b01, 16'h8000, 1'b1, 1'b1, 1);
    send(16'h1234, 16'h0001, 2'b01, 16'h1235, 1'b0, 1'b0, 1);
    send(16'h7FFF, 16'hFFFF, 2'b11, 16'h7FFF, 1'b0, 1'b1, 1);
    send(16'h00F0, 16'h0010, 2'b10, 16'h0000, 1'b0, 1'b0, 1);
    send(16'h0080, 16'h0080, 2'b10, 16'h0080, 1'b0, 1'b1, 1);
    send(16'h00FF, 16'h0001, 2'b00, 16'h0100, 1'b0, 1'b0, 1);
    send(16'h0100, 16'h0001, 2'b11, 16'h00FF, 1'b1, 1'b0, 1);
    drain();

    // Back-to-back 1..6 with the consumer stalled for 3 cycles.
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(16'(i), 16'(i), 2'b00, 16'(2 * i), 1'b0, 1'b0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight.
    send(16'h1111, 16'h2222, 2'b00, 16'h3333, 1'b0, 1'b0, 0);
    send(16'h7000, 16'h1000, 2'b01, 16'h7FFF, 1'b0, 1'b1, 0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    sb.delete();
    exp_sticky = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Clear coincident with an overflowing handover: set wins.
    out_ready = 1'b0;
    send(16'h7000, 16'h1000, 2'b01, 16'h7FFF, 1'b0, 1'b1, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    chk("sticky_set_over_clr", 32'(ovf_sticky), 32'd1);
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    chk("sticky_clr", 32'(ovf_sticky), 32'd0);

    // Pipeline still healthy after reset and clear.
    send(16'h1234, 16'h1111, 2'b10, 16'h2345, 1'b0, 1'b0, 1);
    send(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
